// File: rtl/rd_pipelined_subtractor_pkg.sv
// Shared definitions for the FP-adder subtraction path: kgp codes, widths and
// the prefix combine operator.
package rd_pipelined_subtractor_pkg;

  localparam int WIDTH  = 32;
  localparam int LEVELS = 5;
  localparam int KGP_W  = 2 * WIDTH;

  localparam logic [1:0] KGP_KILL   = 2'b00;
  localparam logic [1:0] KGP_GEN    = 2'b11;
  localparam logic [1:0] KGP_PROP_A = 2'b01;
  localparam logic [1:0] KGP_PROP_B = 2'b10;

  // A resolved (kill/generate) upper span wins; a propagating one defers to lo.
  function automatic logic [1:0] kgp_combine(input logic [1:0] hi, input logic [1:0] lo);
    logic [1:0] res;
    case (hi)
      KGP_PROP_A, KGP_PROP_B: res = lo;
      default:                res = hi;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rd_pipelined_subtractor_prefix_level.sv
// One registered recursive-doubling level of the kgp carry network; bit i
// merges with bit i-DIST, or with kill when no lower partner exists.
module rd_pipelined_subtractor_prefix_level
  import rd_pipelined_subtractor_pkg::*;
#(
  parameter int DIST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             valid_in,
  input  logic [KGP_W-1:0] kgp_in,
  input  logic [WIDTH-1:0] x_in,
  output logic             valid_out,
  output logic [KGP_W-1:0] kgp_out,
  output logic [WIDTH-1:0] x_out
);

  logic [KGP_W-1:0] w_kgp_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= DIST) begin : g_pair
      assign w_kgp_next[2*i +: 2] = kgp_combine(kgp_in[2*i +: 2], kgp_in[2*(i-DIST) +: 2]);
    end else begin : g_edge
      assign w_kgp_next[2*i +: 2] = kgp_combine(kgp_in[2*i +: 2], KGP_KILL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      kgp_out   <= '0;
      x_out     <= '0;
    end else if (advance) begin
      valid_out <= valid_in;
      kgp_out   <= w_kgp_next;
      x_out     <= x_in;
    end
  end

endmodule

// File: rtl/rd_pipelined_subtractor.sv
// Pipelined 32-bit unsigned subtractor D = A - B with borrow-out, one kgp
// prefix level per stage, stalled globally by a single advance signal.
module rd_pipelined_subtractor
  import rd_pipelined_subtractor_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bo
);

  logic                         w_advance;
  logic [WIDTH-1:0]             w_nb;
  logic [WIDTH-1:0]             w_x_in;
  logic [KGP_W-1:0]             w_kgp_fold;
  logic                         r_p0_valid;
  logic [KGP_W-1:0]             r_p0_kgp;
  logic [WIDTH-1:0]             r_p0_x;
  logic [LEVELS:0]              w_valid;
  logic [LEVELS:0][KGP_W-1:0]   w_kgp;
  logic [LEVELS:0][WIDTH-1:0]   w_x;
  logic [WIDTH-1:0]             w_c;
  logic [WIDTH-1:0]             w_unused_lo;

  assign w_advance = ~w_valid[LEVELS] | out_ready;
  assign in_ready  = w_advance;

  assign w_nb   = ~B;
  assign w_x_in = A ^ w_nb;

  // The +1 carry-in is folded into bit 0, which is therefore always resolved.
  always_comb begin
    w_kgp_fold = '0;
    for (int i = 1; i < WIDTH; i++) begin
      w_kgp_fold[2*i +: 2] = {w_nb[i], A[i]};
    end
    w_kgp_fold[1:0] = (!A[0] && B[0]) ? KGP_KILL : KGP_GEN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0_valid <= 1'b0;
      r_p0_kgp   <= '0;
      r_p0_x     <= '0;
    end else if (w_advance) begin
      r_p0_valid <= in_valid;
      if (in_valid) begin
        r_p0_kgp <= w_kgp_fold;
        r_p0_x   <= w_x_in;
      end
    end
  end

  assign w_valid[0] = r_p0_valid;
  assign w_kgp[0]   = r_p0_kgp;
  assign w_x[0]     = r_p0_x;

  for (genvar lv = 0; lv < LEVELS; lv++) begin : g_level
    rd_pipelined_subtractor_prefix_level #(
      .DIST(1 << lv)
    ) u_level (
      .clk      (clk),
      .rst_n    (rst_n),
      .advance  (w_advance),
      .valid_in (w_valid[lv]),
      .kgp_in   (w_kgp[lv]),
      .x_in     (w_x[lv]),
      .valid_out(w_valid[lv+1]),
      .kgp_out  (w_kgp[lv+1]),
      .x_out    (w_x[lv+1])
    );
  end

  // After five levels every pair is kill or generate, so the upper bit is the carry.
  always_comb begin
    w_c         = '0;
    w_unused_lo = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_c[i]         = w_kgp[LEVELS][2*i+1];
      w_unused_lo[i] = w_kgp[LEVELS][2*i];
    end
  end

  assign out_valid = w_valid[LEVELS];
  assign D         = out_valid ? (w_x[LEVELS] ^ {w_c[WIDTH-2:0], 1'b1}) : '0;
  assign Bo        = out_valid & ~w_c[WIDTH-1];

endmodule

// File: tb/tb_rd_pipelined_subtractor.sv
// Directed and random checks of rd_pipelined_subtractor using a cycle-accurate
// scoreboard of expected results, latency and stall behaviour.
module tb_rd_pipelined_subtractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] D;
  logic        Bo;

  int checks;
  int failures;
  int cyc;
  int stall_total;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    int          acc;
    int          snap;
  } exp_t;
  exp_t q[$];

  rd_pipelined_subtractor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .D        (D),
    .Bo       (Bo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the scoreboard, advance.
  task automatic cyc_step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ed, input logic eb, input logic ordy,
                          output logic acc);
    logic due;
    logic exp_ir;
    in_valid  = iv;
    A         = a;
    B         = b;
    out_ready = ordy;
    #1;
    due = (q.size() > 0) && (cyc == q[0].acc + 6 + (stall_total - q[0].snap));
    if (due) chk("result", {30'b0, out_valid, Bo, D}, {30'b0, 1'b1, q[0].bo, q[0].d});
    else     chk("idle_out", {30'b0, out_valid, Bo, D}, 64'd0);
    exp_ir = !(due && !ordy);
    chk("in_ready", {63'b0, in_ready}, {63'b0, exp_ir});
    if (due && ordy) void'(q.pop_front());
    acc = iv && exp_ir;
    if (acc) q.push_back('{ed, eb, cyc, stall_total});
    @(posedge clk);
    #1;
    if (due && !ordy) stall_total++;
    cyc++;
  endtask

  task automatic drain();
    logic acc;
    for (int n = 0; n < 40 && q.size() > 0; n++) cyc_step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic single(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ed, input logic eb);
    logic acc;
    cyc_step(1'b1, a, b, ed, eb, 1'b1, acc);
    chk("single_accept", {63'b0, acc}, 64'd1);
    drain();
  endtask

  initial begin
    logic        acc;
    logic        seen;
    logic        ordy;
    logic [31:0] ra;
    logic [31:0] rb;
    int          k;
    int          sl;

    checks      = 0;
    failures    = 0;
    cyc         = 0;
    stall_total = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    A           = '0;
    B           = '0;
    out_ready   = 1'b1;

    #3;
    chk("reset_state", {30'b0, out_valid, Bo, D}, 64'd0);
    chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    single(32'd5, 32'd3, 32'h0000_0002, 1'b0);
    single(32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1);
    single(32'd0, 32'd0, 32'h0000_0000, 1'b0);
    single(32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0);
    single(32'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    single(32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    single(32'd100, 32'd1, 32'd99, 1'b0);

    // Full-rate streaming.
    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = $urandom;
      cyc_step(1'b1, ra, rb, ra - rb, (ra < rb), 1'b1, acc);
      chk("stream_accept", {63'b0, acc}, 64'd1);
    end
    drain();

    // Backpressure: 4 stalled cycles once the first result appears.
    k    = 0;
    sl   = 4;
    seen = 1'b0;
    ra   = $urandom;
    rb   = $urandom;
    for (int n = 0; n < 60 && (k < 10 || q.size() > 0); n++) begin
      if (out_valid) seen = 1'b1;
      ordy = !(seen && sl > 0);
      if (!ordy) sl--;
      cyc_step(k < 10, ra, rb, ra - rb, (ra < rb), ordy, acc);
      if (acc) begin
        k++;
        ra = $urandom;
        rb = $urandom;
      end
    end
    chk("bp_accepted", 64'(k), 64'd10);
    chk("bp_stalls", 64'(sl), 64'd0);
    drain();

    // Reset with three operations in flight, the first already visible.
    cyc_step(1'b1, 32'd7, 32'd2, 32'd5, 1'b0, 1'b1, acc);
    cyc_step(1'b1, 32'd8, 32'd2, 32'd6, 1'b0, 1'b1, acc);
    cyc_step(1'b1, 32'd9, 32'd2, 32'd7, 1'b0, 1'b1, acc);
    for (int n = 0; n < 3; n++) cyc_step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
    #1;
    chk("pre_reset_valid", {63'b0, out_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", {30'b0, out_valid, Bo, D}, 64'd0);
    chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
    q.delete();
    @(posedge clk);
    #1;
    chk("midrst_hold", {63'b0, out_valid}, 64'd0);
    rst_n = 1'b1;
    single(32'd10, 32'd4, 32'd6, 1'b0);

    // Bubbles: out_valid must replay the in_valid pattern 6 cycles later.
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      cyc_step((i % 2) == 0, ra, rb, ra - rb, (ra < rb), 1'b1, acc);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rd_pipelined_subtractor.md
# rd_pipelined_subtractor

Pipelined 32-bit unsigned subtractor, D = A − B with borrow-out, built as a registered recursive-doubling (kgp parallel-prefix) carry network. It feeds the single-precision floating-point adder's effective-subtraction path, where mantissa differences are formed. It complements the combinational prefix adder.
- One prefix level is registered per cycle.
- Full throughput: one operation per cycle.
- Valid/ready handshakes sit on both sides.

## Interface
Parameters: none (width fixed at 32, 5 prefix levels).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair A/B is presented
- in_ready  out  1  block accepts operands this cycle
- A  in  32  minuend, unsigned
- B  in  32  subtrahend, unsigned
- out_valid  out  1  D/Bo hold a result
- out_ready  in  1  downstream consumes result this cycle
- D  out  32  A − B modulo 2^32
- Bo  out  1  borrow-out: 1 iff A < B unsigned

## Operation
- Subtraction is computed as A + ~B + 1.
- Per-bit kgp code is formed from (~B[i], A[i]):
  - 00 is kill.
  - 11 is generate.
  - 01 and 10 are propagate.
- The carry-in of 1 is folded into bit 0: its code becomes kill iff A[0]=0 and B[0]=1, otherwise generate.
- Prefix combine(hi, lo): result is hi if hi is kill or generate, else lo.
- Positions with no lower partner combine with kill.
- Pipeline registers P0..P5. Each holds a valid bit, a 64-bit kgp vector and a 32-bit x = A ^ ~B.
  - P0 captures the folded kgp vector and x on an accepted transfer.
  - Pk (k=1..5) captures P(k−1) after one doubling level at distance 2^(k−1) (1, 2, 4, 8, 16). x passes through unchanged.
- Resolved carry c[i] is the generate bit of P5 at bit i, i.e. the upper bit of each kgp pair.
- Output equations (combinational from P5):
  - D[0] = x[0] ^ 1.
  - D[i] = x[i] ^ c[i−1] for i ≥ 1.
  - Bo = ~c[31].
- D and Bo are forced to 0 whenever out_valid = 0.
- Flow control uses one global advance signal: advance = ~P5.valid | out_ready.
  - in_ready = advance.
  - All stages shift only when advance = 1. P0.valid loads in_valid.
  - Bubbles are not compressed: an invalid stage still occupies its slot while stalled.
- out_valid = P5.valid.
- A and B are sampled only on in_valid & in_ready.

## Timing
- Latency: operands accepted at edge E give a result loaded into P5 at edge E+5. That result is visible on D/Bo in the cycle after E+5, provided no stall occurs in between.
- Each stalled cycle (out_valid=1, out_ready=0) adds exactly one cycle.
  - All registers hold.
  - in_ready = 0.
  - D/Bo stay stable.
- Back-to-back accepts produce back-to-back results in order. No operation is dropped or duplicated.
- A simultaneous output consume and input accept in the same cycle is legal and required at full rate.
- Reset (asynchronous assert, any time including mid-pipeline):
  - All valid bits, kgp and x registers clear to 0.
  - Outputs go to out_valid=0, D=0, Bo=0, in_ready=1.
  - In-flight operations are discarded.
- No combinational path from out_ready to in_ready other than the advance term. No combinational path from A/B to any output.

## Structure
- Shared FP-adder package holds:
  - kgp encoding constants KGP_KILL=2'b00, KGP_GEN=2'b11, KGP_PROP_A=2'b01, KGP_PROP_B=2'b10.
  - The kgp combine function.
  - WIDTH=32 and LEVELS=5.
- The natural sub-module is prefix_level: one registered doubling level with parameter DIST.
  - It has inputs kgp_in[63:0], x_in, valid_in and advance.
  - It has outputs kgp_out, x_out and valid_out.
  - It is instantiated five times with DIST = 1, 2, 4, 8, 16.
- P0 formation and the output equations live in the top module.

## Test plan
- Single op: A=5, B=3 → after 6 cycles out_valid=1, D=0x00000002, Bo=0. A=3, B=5 → D=0xFFFFFFFE, Bo=1.
- Boundaries:
  - A=0, B=0 → D=0, Bo=0.
  - A=0x80000000, B=1 → D=0x7FFFFFFF, Bo=0.
  - A=0, B=0xFFFFFFFF → D=0x00000001, Bo=1.
  - A=B=0xDEADBEEF → D=0, Bo=0.
- Streaming: 100 random pairs on consecutive cycles with out_ready=1 → 100 results on consecutive cycles, in order, matching a reference model. in_ready stays 1 throughout.
- Backpressure: stream 10 ops and hold out_ready=0 for 4 cycles once out_valid rises.
  - in_ready=0 during the stall.
  - D/Bo stay stable.
  - After release, all 10 results arrive in order with none lost or duplicated.
- Reset mid-operation: assert rst_n=0 with 3 ops in flight.
  - Outputs go to out_valid=0, D=0, Bo=0, in_ready=1 immediately.
  - After release, a new op A=10, B=4 returns D=6, Bo=0 with nominal latency.
- Bubbles: alternate in_valid 1/0 with out_ready=1 → out_valid alternates the same pattern, delayed by 6 cycles.
